// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter.
package mem_arb_pkg;

  localparam int WAIT_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin pick between IFU and LSU requests.
module mem_rr_pick
  import mem_arb_pkg::*;
(
  input  logic   ifu_req,
  input  logic   lsu_req,
  input  owner_e last_owner,
  output logic   valid,
  output owner_e owner
);

  always_comb begin
    valid = ifu_req | lsu_req;
    owner = OWN_IFU;
    unique case (1'b1)
      (ifu_req & lsu_req):
        owner = (last_owner == OWN_IFU) ? OWN_LSU : OWN_IFU;
      (lsu_req & ~ifu_req):
        owner = OWN_LSU;
      default:
        owner = OWN_IFU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data memory between IFU and LSU,
// runs a fixed-latency access and returns data with a ready pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_gnt,
  output logic                ifu_ready,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_be,
  output logic                lsu_gnt,
  output logic                lsu_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ifu_rdy_q, ifu_rdy_d;
  logic                lsu_rdy_q, lsu_rdy_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;

  logic   pick_valid;
  owner_e pick_owner;

  mem_rr_pick u_pick (
    .ifu_req    (ifu_req),
    .lsu_req    (lsu_req),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .owner      (pick_owner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rdata_d      = rdata_q;
    ifu_rdy_d    = 1'b0;
    lsu_rdy_d    = 1'b0;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    ifu_gnt      = 1'b0;
    lsu_gnt      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d  = pick_owner;
          cnt_d    = CNT_LOAD;
          mem_en_d = 1'b1;
          state_d  = ACCESS;
          if (pick_owner == OWN_LSU) begin
            lsu_gnt  = 1'b1;
            we_d     = lsu_we;
            addr_d   = lsu_addr;
            wdata_d  = lsu_wdata;
            be_d     = lsu_we ? lsu_be : '1;
            mem_we_d = lsu_we;
          end else begin
            ifu_gnt  = 1'b1;
            we_d     = 1'b0;
            addr_d   = ifu_addr;
            wdata_d  = '0;
            be_d     = '1;
            mem_we_d = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        // Final access edge: capture read data and hand over to DONE.
        if (cnt_q <= CNT_ONE) begin
          state_d   = DONE;
          mem_en_d  = 1'b0;
          mem_we_d  = 1'b0;
          ifu_rdy_d = (owner_q == OWN_IFU);
          lsu_rdy_d = (owner_q == OWN_LSU);
          if (!we_q) rdata_d = mem_rdata;
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_owner_q <= OWN_IFU;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata_q      <= '0;
      ifu_rdy_q    <= 1'b0;
      lsu_rdy_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rdata_q      <= rdata_d;
      ifu_rdy_q    <= ifu_rdy_d;
      lsu_rdy_q    <= lsu_rdy_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign ifu_ready = ifu_rdy_q;
  assign lsu_ready = lsu_rdy_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with WAIT_CYCLES=3.
module tb_mem_arbiter;

  localparam int W = 3;

  typedef struct {
    logic        own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd;
    int          hold;
    int          gap;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req, ifu_gnt, ifu_ready;
  logic [31:0] ifu_addr;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_ready;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_be;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  cmd_t ifu_q[$];
  cmd_t lsu_q[$];
  cmd_t exp_q[$];
  cmd_t ifu_cur, lsu_cur, cur;
  logic ifu_act = 0, lsu_act = 0;
  logic prev_ifu_rdy = 0, prev_lsu_rdy = 0;
  logic busy = 0, saw_gnt = 0;
  int   ifu_hold = 0;
  int   gcyc = 0, en_cnt = 0, last_rdy = 0;
  logic [31:0] model_rd = '0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ifu_req   (ifu_req),
    .ifu_addr  (ifu_addr),
    .ifu_gnt   (ifu_gnt),
    .ifu_ready (ifu_ready),
    .lsu_req   (lsu_req),
    .lsu_we    (lsu_we),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_be    (lsu_be),
    .lsu_gnt   (lsu_gnt),
    .lsu_ready (lsu_ready),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5555AAAA;
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_ifu(input logic [31:0] a, input int hold,
                          input int gap);
    cmd_t c;
    c.own = 1'b0; c.we = 1'b0; c.addr = a; c.wdata = '0;
    c.be = 4'hF; c.rd = mem_fn(a); c.hold = hold; c.gap = gap;
    ifu_q.push_back(c);
    exp_q.push_back(c);
  endtask

  task automatic push_lsu(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int gap);
    cmd_t c;
    c.own = 1'b1; c.we = we; c.addr = a; c.wdata = wd;
    c.be = we ? be : 4'hF; c.rd = mem_fn(a); c.hold = 0; c.gap = gap;
    lsu_q.push_back(c);
    exp_q.push_back(c);
  endtask

  task automatic drive();
    if (ifu_hold > 0) begin
      ifu_hold--;
      if (ifu_hold == 0) ifu_act = 0;
    end
    if (prev_ifu_rdy && ifu_act) ifu_act = 0;
    if (prev_lsu_rdy && lsu_act) lsu_act = 0;
    if (!ifu_act && ifu_q.size() > 0) begin
      ifu_cur = ifu_q.pop_front();
      ifu_act = 1;
    end
    if (!lsu_act && lsu_q.size() > 0) begin
      lsu_cur = lsu_q.pop_front();
      lsu_act = 1;
    end
    ifu_req   = ifu_act;
    ifu_addr  = ifu_cur.addr;
    lsu_req   = lsu_act;
    lsu_we    = lsu_cur.we;
    lsu_addr  = lsu_cur.addr;
    lsu_wdata = lsu_cur.wdata;
    lsu_be    = lsu_cur.we ? lsu_cur.be : 4'h0;
  endtask

  task automatic monitor();
    cmd_t e;
    chk("gnt_1hot", 32'(ifu_gnt & lsu_gnt), 0);
    chk("rdy_1hot", 32'(ifu_ready & lsu_ready), 0);
    chk("gnt_rdy_excl",
        32'((ifu_gnt & ifu_ready) | (lsu_gnt & lsu_ready)), 0);
    if (mem_we) chk("we_implies_en", 32'(mem_en), 1);
    if (ifu_gnt | lsu_gnt) begin
      saw_gnt = 1;
      if (exp_q.size() == 0) chk("spurious_gnt", 1, 0);
      else begin
        cur = exp_q[0];
        chk("gnt_owner", 32'(lsu_gnt), 32'(cur.own));
        if (cur.gap >= 0) chk("gnt_gap", 32'(cyc - last_rdy), 32'(cur.gap));
        busy = 1; gcyc = cyc; en_cnt = 0;
        if (ifu_gnt) ifu_hold = ifu_cur.hold;
      end
    end
    if (mem_en) begin
      en_cnt++;
      if (busy) begin
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        chk("mem_be", 32'(mem_be), 32'(cur.be));
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      end
    end
    if (ifu_ready | lsu_ready) begin
      if (exp_q.size() == 0) chk("spurious_rdy", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rdy_owner", 32'(lsu_ready), 32'(e.own));
        chk("latency", 32'(cyc - gcyc), W + 1);
        chk("en_cycles", 32'(en_cnt), W);
        if (!e.we) model_rd = e.rd;
        chk("rdata", rdata, model_rd);
      end
      busy = 0;
      last_rdy = cyc;
    end
    prev_ifu_rdy = ifu_ready;
    prev_lsu_rdy = lsu_ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_idle(input int extra);
    int n = 0;
    while ((exp_q.size() > 0 || ifu_q.size() > 0 || lsu_q.size() > 0 ||
            ifu_act || lsu_act) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("timeout", 1, 0);
    repeat (extra) step();
  endtask

  task automatic chk_reset_vals();
    chk("rst_ifu_gnt", 32'(ifu_gnt), 0);
    chk("rst_lsu_gnt", 32'(lsu_gnt), 0);
    chk("rst_ifu_rdy", 32'(ifu_ready), 0);
    chk("rst_lsu_rdy", 32'(lsu_ready), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_rdata", rdata, 0);
  endtask

  initial begin
    int n;
    reset = 1;
    ifu_cur = '{default: 0};
    lsu_cur = '{default: 0};
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    reset = 0;

    // Tie after reset: L, I, L, I with both held
    push_lsu(1'b0, 32'h010, '0, 4'h0, -1);
    push_ifu(32'h020, 0, 1);
    push_lsu(1'b0, 32'h014, '0, 4'h0, 1);
    push_ifu(32'h024, 0, 1);
    wait_idle(3);

    // Lone LSU load and store
    push_lsu(1'b0, 32'h100, '0, 4'h0, -1);
    wait_idle(2);
    chk("load_rdata", rdata, 32'hDEADBEEF);
    push_lsu(1'b1, 32'h104, 32'h12345678, 4'b0011, -1);
    wait_idle(2);
    chk("store_keeps_rdata", rdata, 32'hDEADBEEF);

    // IFU drops req mid-access
    push_ifu(32'h200, 2, -1);
    wait_idle(8);

    // Back-to-back IFU reissue
    push_ifu(32'h300, 0, -1);
    push_ifu(32'h304, 0, 1);
    push_ifu(32'h308, 0, 1);
    wait_idle(3);

    // Reset mid-access
    push_lsu(1'b1, 32'h400, 32'hCAFEF00D, 4'hC, -1);
    saw_gnt = 0;
    n = 0;
    while (!saw_gnt && n < 20) begin
      step();
      n++;
    end
    if (!saw_gnt) chk("rst_gnt_timeout", 1, 0);
    step();
    step();
    chk("pre_rst_mem_we", 32'(mem_we), 1);
    reset = 1;
    #1;
    chk("rst_async_en", 32'(mem_en), 0);
    chk("rst_async_we", 32'(mem_we), 0);
    ifu_q.delete(); lsu_q.delete(); exp_q.delete();
    ifu_act = 0; lsu_act = 0; ifu_hold = 0; busy = 0;
    prev_ifu_rdy = 0; prev_lsu_rdy = 0; model_rd = '0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    reset = 0;
    repeat (6) step();
    push_lsu(1'b0, 32'h500, '0, 4'h0, -1);
    push_ifu(32'h504, 0, 1);
    wait_idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port data memory between the instruction-fetch unit (IFU) and the load/store unit (LSU). The block arbitrates between the two requesters and latches the winner's command. It drives the memory for a fixed number of wait cycles, then returns read data with a one-cycle ready pulse. It sits between the IFU/LSU request ports and the memory macro, and owns all memory-side control signals.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- WAIT_CYCLES, 3, memory access cycles before data is valid; legal range ≥1

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- ifu_req  in  1  IFU read request, held until ifu_ready
- ifu_addr  in  ADDR_W  IFU word address
- ifu_gnt  out  1  one-cycle pulse: IFU command latched
- ifu_ready  out  1  one-cycle pulse: IFU access complete, rdata valid
- lsu_req  in  1  LSU request, held until lsu_ready
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  ADDR_W  LSU address
- lsu_wdata  in  DATA_W  store data
- lsu_be  in  DATA_W/8  store byte enables
- lsu_gnt  out  1  one-cycle pulse: LSU command latched
- lsu_ready  out  1  one-cycle pulse: LSU access complete
- rdata  out  DATA_W  read data, shared by both requesters
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_be  out  DATA_W/8  latched byte enables; all ones for reads
- mem_rdata  in  DATA_W  memory read data

## Operation
FSM has three states: IDLE, ACCESS, DONE.

**IDLE**
- With no request, the FSM stays in IDLE.
- With one request, that requester wins.
- With both requesting, the requester that did not win last wins (round-robin). `last_owner` resets to IFU, so the LSU wins the first tie.
- On a win:
  - assert the winner's gnt for this cycle;
  - latch addr/we/wdata/be; an IFU access always has we=0 and be all ones;
  - load the counter with WAIT_CYCLES;
  - go to ACCESS.

**ACCESS**
- mem_en=1; mem_we = latched we.
- The counter decrements on each edge.
- On the edge where the counter goes 1→0:
  - for a read, capture mem_rdata into rdata;
  - go to DONE.

**DONE**
- Assert the owner's ready for one cycle.
- mem_en=0.
- Update last_owner.
- Go to IDLE.

**Requester rules**
- A requester keeps req and its command fields stable until it samples ready high. It drops req, or issues a new command, on that same edge.
- Dropping req during ACCESS is ignored; the access completes and ready still pulses.

**Data and widths**
- rdata holds its value until the next read capture; writes leave it unchanged.
- The counter is $clog2(WAIT_CYCLES+1) bits and never wraps below 0.

## Timing
- **Reset values:** all outputs 0 (gnt, ready, mem_en, mem_we, mem_addr, mem_wdata, mem_be, rdata); state IDLE; last_owner IFU; counter 0.
- **Latency:** gnt in cycle T; ACCESS occupies T+1..T+WAIT_CYCLES; ready in T+WAIT_CYCLES+1. The next grant comes no earlier than T+WAIT_CYCLES+2, which gives WAIT_CYCLES+2 cycles per access.
- **Back-to-back tie:** consecutive accesses alternate owners strictly.
- **Simultaneous events:** a request arriving during ACCESS or DONE waits for IDLE. gnt and ready are never high for the same requester in the same cycle.
- **Reset mid-access:** asynchronous. mem_en and mem_we drop immediately, the access is abandoned, and no ready is issued.
- **Invariants:** gnt and ready are one-hot across the two requesters. mem_we=1 implies mem_en=1.

## Structure
- **Shared package mem_arb_pkg:**
  - state encoding (IDLE, ACCESS, DONE);
  - owner encoding (OWN_IFU=0, OWN_LSU=1);
  - default WAIT_CYCLES.
- **Sub-module mem_rr_pick:** a combinational 2-way round-robin pick.
  - Inputs: ifu_req, lsu_req, last_owner.
  - Outputs: valid, owner.
- **Top level:** holds the FSM, wait counter, command latch and rdata capture.

## Test plan
All scenarios use WAIT_CYCLES=3.
- **Lone LSU load:** LSU load, addr 0x100, mem_rdata=0xDEADBEEF → lsu_gnt at T, mem_en T+1..T+3, lsu_ready and rdata=0xDEADBEEF at T+4.
- **Lone LSU store:** LSU store, addr 0x104, wdata 0x12345678, be 4'b0011 → mem_we=1 with those fields for 3 cycles; rdata unchanged; lsu_ready at T+4.
- **Tie after reset:** both request in the same cycle → LSU granted first, IFU granted at T+5. With both held continuously, owners alternate L, I, L, I.
- **Request dropped mid-access:** IFU drops req during ACCESS → access completes and ifu_ready still pulses; no second grant follows.
- **Reset mid-access:** reset asserted at T+2 → mem_en=0 the same cycle, no ready, IDLE after release; the LSU wins the next tie.
- **Back-to-back IFU:** IFU reissues on the ready edge → next ifu_gnt exactly 1 cycle after ifu_ready, for 5 cycles per access.
